// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a common-anode 7-segment display. Every digit
// gets a slot of DIGIT_CYCLES clocks. The first BLANK_CYCLES clocks of a slot
// keep all anodes off to prevent ghosting. The rest of the slot drives the
// digit's active-low anode and its cathode byte. The whole display bus is
// snapshotted once per frame, so a value change never tears mid-scan.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   display      DIGITS*8 flattened cathode bytes, byte i = digit i
//   brightness   4-bit duty setting (only when SEG_SCAN_BRIGHTNESS_EN)
//   AN           active-low anode enables, at most one bit low
//   CAT          cathode byte of the lit digit, 8'hFF when nothing is lit
//   digit_idx    digit whose slot is in progress
//   frame_start  one-cycle pulse in the first cycle of digit 0's slot
//
// Build option:
//   SEG_SCAN_BRIGHTNESS_EN -- adds the brightness input. Inside the ON part
//   of a slot, the anode is enabled only while the low nibble of
//   (counter - BLANK_CYCLES) <= brightness. brightness is held per frame and
//   resets to 15 (full on).
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS*8-1:0]   display,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            CAT,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_start
);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] DIG_LAST   = IW'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       digit_q, digit_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q;
  logic [7:0]          frame_q [DIGITS];
  logic [7:0]          frame_d [DIGITS];
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          cat_q, cat_d;
  logic                fs_q, fs_d;
  logic                snap;
  logic                lit;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]          bright_q, bright_d;
`endif

  // Snapshot on the edge that ends the first cycle of a frame.
  assign snap = (state_q == ST_BLANK) && (digit_q == '0) && (cnt_q == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_frame
      assign frame_d[gi] = snap ? display[gi*8 +: 8] : frame_q[gi];
    end
  endgenerate

`ifdef SEG_SCAN_BRIGHTNESS_EN
  assign bright_d = snap ? brightness : bright_q;
`endif

  // Next-state logic for the FSM.
  // run_q is low for the single cycle after reset release. In that cycle the
  // scan position holds at digit 0 / BLANK / count 0. This lets the output
  // flops load the count-0 values, so the first visible cycle after reset
  // already shows frame_start.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_BLANK;
        digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
        end
      end
    end
  end

  // Output registers are loaded from the next-state values.
  // This makes AN/CAT/digit_idx/frame_start describe the cycle they are
  // visible in. CAT reads frame_d so a digit that lights right after the
  // snapshot edge already shows the new frame.
  always_comb begin
    lit = (state_d == ST_ON);
`ifdef SEG_SCAN_BRIGHTNESS_EN
    if ((4'(cnt_d) - 4'(BLANK_CYCLES)) > bright_d) begin
      lit = 1'b0;
    end
`endif
    an_d  = '1;
    cat_d = 8'hFF;
    if (lit) begin
      an_d  = ~(DIGITS'(1) << digit_d);
      cat_d = frame_d[digit_d];
    end
    fs_d = (state_d == ST_BLANK) && (digit_d == '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_BLANK;
      digit_q  <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      an_q     <= '1;
      cat_q    <= 8'hFF;
      fs_q     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        frame_q[i] <= 8'hFF;
      end
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_q <= 4'hF;
`endif
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cnt_q    <= cnt_d;
      run_q    <= 1'b1;
      an_q     <= an_d;
      cat_q    <= cat_d;
      fs_q     <= fs_d;
      for (int i = 0; i < DIGITS; i++) begin
        frame_q[i] <= frame_d[i];
      end
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end

  assign AN          = an_q;
  assign CAT         = cat_q;
  assign digit_idx   = digit_q;
  assign frame_start = fs_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the flattened per-digit cathode bus produced by the calculator display path and drives the board's multiplexed 7-segment hardware.
- Drives one digit at a time: active-low anode strobe plus that digit's cathode byte.
- Inserts a blanking gap between digits to prevent ghosting.
- Snapshots the whole display once per frame so a value change never tears mid-scan.

Parameters:
- DIGITS, 8: number of digits; taken from types_pkg.
- DIGIT_CYCLES, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- display  input  DIGITS*8  flattened cathode patterns; byte i = digit i; passed through unmodified
- AN  output  DIGITS  anode enables, active-low, at most one bit low
- CAT  output  8  cathode pattern of the active digit; 8'hFF = all segments off
- digit_idx  output  $clog2(DIGITS)  digit currently in its slot
- frame_start  output  1  one-cycle pulse in the first cycle of digit 0's slot

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low, on rst. Ports are named clk and rst.
- Reset values: state=BLANK, digit_idx=0, slot counter=0, AN all 1s, CAT=8'hFF, frame_start=0, frame register all 8'hFF.
- State machine: two states, BLANK and ON.
  - BLANK: AN all 1s, CAT=8'hFF. Lasts BLANK_CYCLES cycles, then goes to ON.
  - ON: AN[digit_idx]=0, all other AN bits 1, CAT=frame[digit_idx]. Lasts DIGIT_CYCLES-BLANK_CYCLES cycles.
  - After the last ON cycle: back to BLANK with digit_idx+1. digit_idx wraps DIGITS-1 -> 0.
- Slot counter: runs 0..DIGIT_CYCLES-1 within each slot.
  - BLANK covers counts 0..BLANK_CYCLES-1; ON covers the rest.
  - Each slot is exactly DIGIT_CYCLES cycles; a frame is DIGITS*DIGIT_CYCLES cycles.
- Snapshot:
  - The frame register loads display on the clock edge that ends the cycle where state=BLANK, digit_idx=0 and counter=0.
  - frame_start=1 in exactly that cycle, 0 otherwise.
  - Changes to display at any other time are invisible until the next frame.
  - Because reset leaves the block in that cycle, the first edge after reset release captures display.
- Registered outputs: AN, CAT, digit_idx and frame_start come from flops (no combinational path from display to CAT). In any cycle they reflect that cycle's state, digit and counter.
- Invariants checked by the bench:
  - Never more than one AN bit low.
  - CAT=8'hFF whenever AN is all 1s.
- Reset mid-scan: outputs go to reset values immediately (asynchronous). Scanning restarts at digit 0, BLANK, counter 0.
- Width rules: the counter is wide enough for DIGIT_CYCLES-1. digit_idx width is $clog2(DIGITS), minimum 1.

Optional Feature:
- Macro: SEG_SCAN_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness, 4 bits, sampled at frame_start and held for the frame.
  - In ON, the anode is enabled only while the low 4 bits of (counter-BLANK_CYCLES) <= brightness. Otherwise AN is all 1s and CAT=8'hFF.
  - brightness=15 means full on; brightness=0 gives 1/16 duty.
  - Reset value of the held brightness is 15.
- Not defined: no brightness port; ON is always fully lit.

Test Plan:
All scenarios use DIGITS=4, DIGIT_CYCLES=10, BLANK_CYCLES=2.
- Reset, display=32'h11_22_33_44, release rst -> cycles 0-1: AN=4'hF, CAT=FF, frame_start=1 in cycle 0. Cycles 2-9: AN=4'hE, CAT=8'h44. Cycles 12-19: AN=4'hD, CAT=8'h33. Cycle 40: frame_start=1, digit_idx=0.
- Change display to 32'hAA_BB_CC_DD at cycle 15 -> digits 1-3 of frame 0 still show 33/22/11. From cycle 42: AN=4'hE, CAT=8'hDD.
- Run 3 full frames, check every cycle -> at most one AN bit 0; CAT=FF whenever AN=4'hF; each digit lit exactly 8 cycles per frame.
- Assert rst low at cycle 25 (digit 2 in ON) for 3 cycles -> AN=4'hF and CAT=FF in the same cycle as the assertion. After release: digit_idx=0, BLANK, frame_start=1.
- SEG_SCAN_BRIGHTNESS_EN, brightness=3 at frame_start -> digit 0 lit cycles 2-5 only, AN=4'hF in cycles 6-9. With brightness=15 -> lit cycles 2-9.
